draw_arbiter: RTL and testbench

Shared-access controller for the object/background drawing datapath. Accepts draw jobs from up to four requesters (start page, level setup, hook motion, pull-back), grants the datapath to one at a time in round-robin order, and emits the per-cycle control strobes that sequence a 32x32 sprite draw/erase or a full 320x240 background fill. It sits between the game FSMs and the datapath, and drives the VGA adapter's plot enable.

---
 rtl/draw_arbiter.sv | 169 ++++++++++++++++
 tb/tb_draw_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
// Round-robin owner of the sprite/background drawing datapath: grants one of four
// requesters at a time and sequences the per-pixel control strobes for its job.
module draw_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [35:0] req_x,
  input  logic [31:0] req_y,
  input  logic [19:0] req_type,
  input  logic [7:0]  req_kind,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [8:0]  x_start,
  output logic [7:0]  y_start,
  output logic [4:0]  object_type,
  output logic        erase,
  output logic        read_mem,
  output logic        reset_counter_object,
  output logic        load_colour,
  output logic        store_type,
  output logic        store_current_bg,
  output logic        enable_counter_object,
  output logic        ld_bg,
  output logic        reset_counter_address_background,
  output logic        ld_colour_bg,
  output logic        enable_counter_address_background,
  output logic        plot
);

  typedef enum logic [3:0] {
    IDLE, ARB, S_LOAD, S_FETCH, S_COLOUR, S_PLOT, B_LOAD, B_COLOUR, B_PLOT, DONE
  } state_t;

  localparam logic [16:0] SPR_LAST = 17'd1023;
  localparam logic [16:0] BG_LAST  = 17'd76799;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [4:0]  type_q, type_d;
  logic        erase_q, erase_d;
  logic [16:0] pix_q, pix_d;

  logic [1:0]  idx;
  logic [1:0]  win;
  logic        found;
  logic [1:0]  kind;

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    idx   = 2'd0;
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    erase_d = erase_q;
    pix_d   = pix_q;
    kind    = req_kind[int'(win) * 2 +: 2];
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (found) begin
          gnt_d   = 4'b0001 << win;
          last_d  = win;
          x_d     = req_x[int'(win) * 9 +: 9];
          y_d     = req_y[int'(win) * 8 +: 8];
          type_d  = req_type[int'(win) * 5 +: 5];
          erase_d = (kind == 2'd1);
          state_d = (kind == 2'd2) ? B_LOAD : S_LOAD;
        end else begin
          // Request vanished between IDLE and ARB: nothing to grant.
          state_d = IDLE;
        end
      end
      S_LOAD: begin
        pix_d   = 17'd0;
        state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_COLOUR;
      S_COLOUR: state_d = S_PLOT;
      S_PLOT: begin
        if (pix_q == SPR_LAST) begin
          state_d = DONE;
        end else begin
          pix_d   = pix_q + 17'd1;
          state_d = S_FETCH;
        end
      end
      B_LOAD: begin
        pix_d   = 17'd0;
        state_d = B_COLOUR;
      end
      B_COLOUR: state_d = B_PLOT;
      B_PLOT: begin
        if (pix_q == BG_LAST) state_d = DONE;
        else                  pix_d   = pix_q + 17'd1;
      end
      DONE: begin
        gnt_d   = 4'b0000;
        erase_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      type_q  <= 5'd0;
      erase_q <= 1'b0;
      pix_q   <= 17'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      erase_q <= erase_d;
      pix_q   <= pix_d;
    end
  end

  // Every output is a decode of registered state; req never reaches an output directly.
  assign gnt         = gnt_q;
  assign busy        = |gnt_q;
  assign done        = (state_q == DONE) ? gnt_q : 4'b0000;
  assign x_start     = x_q;
  assign y_start     = y_q;
  assign object_type = type_q;
  assign erase       = erase_q;

  assign read_mem              = (state_q == S_LOAD);
  assign reset_counter_object  = (state_q == S_LOAD);
  assign load_colour           = (state_q == S_COLOUR);
  assign store_type            = (state_q == S_COLOUR) && (pix_q == 17'd0);
  assign store_current_bg      = (state_q == S_PLOT);
  assign enable_counter_object = (state_q == S_PLOT);

  assign ld_bg                             = (state_q == B_LOAD);
  assign reset_counter_address_background  = (state_q == B_LOAD);
  assign ld_colour_bg                      = (state_q == B_COLOUR);
  assign enable_counter_address_background = (state_q == B_PLOT);

  assign plot = (state_q == S_PLOT) || (state_q == B_PLOT);

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected jobs are queued as requests are driven
// and checked against grant/strobe/done activity observed on the falling edge.
module tb_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [35:0] req_x;
  logic [31:0] req_y;
  logic [19:0] req_type;
  logic [7:0]  req_kind;
  logic [3:0]  gnt, done;
  logic        busy, erase, plot;
  logic [8:0]  x_start;
  logic [7:0]  y_start;
  logic [4:0]  object_type;
  logic        read_mem, reset_counter_object, load_colour, store_type;
  logic        store_current_bg, enable_counter_object;
  logic        ld_bg, reset_counter_address_background, ld_colour_bg;
  logic        enable_counter_address_background;

  draw_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_type(req_type), .req_kind(req_kind), .gnt(gnt), .done(done), .busy(busy),
    .x_start(x_start), .y_start(y_start), .object_type(object_type), .erase(erase),
    .read_mem(read_mem), .reset_counter_object(reset_counter_object),
    .load_colour(load_colour), .store_type(store_type),
    .store_current_bg(store_current_bg), .enable_counter_object(enable_counter_object),
    .ld_bg(ld_bg), .reset_counter_address_background(reset_counter_address_background),
    .ld_colour_bg(ld_colour_bg),
    .enable_counter_address_background(enable_counter_address_background),
    .plot(plot)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] gnt;
    logic       bg;
    logic       erase;
    logic [8:0] x;
    logic [7:0] y;
    logic [4:0] t;
    logic       gap;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_done = 0, gnt_cyc = 0, done_cyc = 0, req_cyc = 0;
  int n_plot, n_lc, n_st, n_rm, n_rco, n_eco, n_scb, n_ldbg, n_rcab, n_lcbg, n_ecab;
  int run, max_run, lc_bad, prm_bad, er_bad;
  int multi_gnt = 0, multi_done = 0, busy_bad = 0, stray_bad = 0;
  logic [3:0] prev_gnt = 4'b0000;
  logic prev_lc = 1'b0;
  logic [42:0] allo;

  assign allo = {gnt, done, busy, x_start, y_start, object_type, erase, read_mem,
                 reset_counter_object, load_colour, store_type, store_current_bg,
                 enable_counter_object, ld_bg, reset_counter_address_background,
                 ld_colour_bg, enable_counter_address_background, plot};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      prev_gnt = 4'b0000;
      prev_lc  = 1'b0;
    end else begin
      if ($countones(gnt) > 1) multi_gnt++;
      if ($countones(done) > 1) multi_done++;
      if (busy != (gnt != 4'b0000)) busy_bad++;
      if ((erase || done != 4'b0000) && gnt == 4'b0000) stray_bad++;
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        {n_plot, n_lc, n_st, n_rm, n_rco, n_eco, n_scb} = '0;
        {n_ldbg, n_rcab, n_lcbg, n_ecab, run, max_run, lc_bad, prm_bad, er_bad} = '0;
        gnt_cyc = cyc;
        if (q.size() == 0) check("unexpected_gnt", gnt, 0);
        else begin
          e = q[0];
          check($sformatf("gnt_order_%b", e.gnt), gnt, e.gnt);
          if (e.gap) check($sformatf("gnt_gap_%b", e.gnt), cyc - done_cyc, 3);
        end
      end
      if (gnt != 4'b0000 && q.size() > 0) begin
        if (plot) begin
          n_plot++; run++;
          if (run > max_run) max_run = run;
          if (!e.bg && !prev_lc) lc_bad++;
        end else run = 0;
        n_lc += int'(load_colour);  n_st += int'(store_type);  n_rm += int'(read_mem);
        n_rco += int'(reset_counter_object); n_eco += int'(enable_counter_object);
        n_scb += int'(store_current_bg); n_ldbg += int'(ld_bg);
        n_rcab += int'(reset_counter_address_background);
        n_lcbg += int'(ld_colour_bg); n_ecab += int'(enable_counter_address_background);
        if (x_start != e.x || y_start != e.y || object_type != e.t) prm_bad++;
        if (erase != e.erase) er_bad++;
      end
      if (done != 4'b0000) begin
        n_done++;
        done_cyc = cyc;
        if (q.size() == 0) check("unexpected_done", done, 0);
        else begin
          e = q.pop_front();
          check("done_bit", done, e.gnt);
          check("param_stable", prm_bad, 0);
          check("erase_window", er_bad, 0);
          if (e.bg) begin
            check("bg_plots", n_plot, 76800);
            check("bg_plot_run", max_run, 76800);
            check("bg_en_cnt", n_ecab, 76800);
            check("bg_ld_bg", n_ldbg, 1);
            check("bg_rst_cnt", n_rcab, 1);
            check("bg_ld_colour", n_lcbg, 1);
            check("bg_sprite_strobes", n_lc + n_st + n_rm + n_rco + n_eco + n_scb, 0);
            check("bg_latency", done_cyc - gnt_cyc, 76802);
          end else begin
            check($sformatf("spr_plots_%b", e.gnt), n_plot, 1024);
            check("spr_load_colour", n_lc, 1024);
            check("spr_lc_before_plot", lc_bad, 0);
            check("spr_store_type", n_st, 1);
            check("spr_read_mem", n_rm, 1);
            check("spr_rst_cnt", n_rco, 1);
            check("spr_en_cnt", n_eco, 1024);
            check("spr_store_bg", n_scb, 1024);
            check("spr_bg_strobes", n_ldbg + n_rcab + n_lcbg + n_ecab, 0);
            check("spr_latency", done_cyc - gnt_cyc, 3073);
          end
        end
      end
      prev_gnt = gnt;
      prev_lc  = load_colour;
    end
  end

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_done < target; i++) begin
      @(negedge clock); #1;
    end
    check(tag, n_done, target);
  endtask

  task automatic wait_gnt(input logic [3:0] g, input int budget, input string tag);
    for (int i = 0; i < budget && gnt != g; i++) begin
      @(negedge clock); #1;
    end
    check(tag, gnt, g);
  endtask

  initial begin
    req_x    = {9'd255, 9'd300, 9'd7, 9'd100};
    req_y    = {8'd239, 8'd200, 8'd9, 8'd50};
    req_type = {5'd17, 5'd31, 5'd1, 5'd3};
    req_kind = {2'd1, 2'd0, 2'd3, 2'd0};
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("reset_outputs", allo, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    q.push_back('{gnt: 4'b0001, bg: 1'b0, erase: 1'b0, x: 9'd100, y: 8'd50, t: 5'd3, gap: 1'b0});
    q.push_back('{gnt: 4'b0010, bg: 1'b0, erase: 1'b0, x: 9'd7,   y: 8'd9,  t: 5'd1, gap: 1'b1});
    q.push_back('{gnt: 4'b0100, bg: 1'b0, erase: 1'b0, x: 9'd300, y: 8'd200, t: 5'd31, gap: 1'b1});
    q.push_back('{gnt: 4'b1000, bg: 1'b0, erase: 1'b1, x: 9'd255, y: 8'd239, t: 5'd17, gap: 1'b1});
    q.push_back('{gnt: 4'b0001, bg: 1'b0, erase: 1'b0, x: 9'd100, y: 8'd50, t: 5'd3, gap: 1'b1});
    @(posedge clock); #1;
    req = 4'b1111;
    req_cyc = cyc;
    wait_done(1, 3200, "job0_done");
    check("job0_req_to_done", done_cyc - req_cyc, 3075);

    // Requester 1 lets go of its request partway through its job.
    wait_gnt(4'b0010, 20, "job1_gnt_seen");
    repeat (100) @(posedge clock);
    #1 req[1] = 1'b0;
    wait_done(2, 3200, "job1_done_after_drop");
    req[1] = 1'b1;
    wait_done(3, 3200, "job2_done");
    wait_done(4, 3200, "job3_done");

    // Abort requester 0's second job mid-sprite.
    for (int i = 0; i < 1700 && !(gnt == 4'b0001 && n_plot >= 500); i++) begin
      @(negedge clock); #1;
    end
    check("abort_point_plots", n_plot, 500);
    reset = 1'b1;
    #1 check("abort_outputs", allo, 0);
    q.delete();
    repeat (4) @(posedge clock);
    #1 check("no_done_after_abort", n_done, 4);
    q.push_back('{gnt: 4'b0001, bg: 1'b0, erase: 1'b0, x: 9'd100, y: 8'd50, t: 5'd3, gap: 1'b0});
    reset = 1'b0;
    wait_gnt(4'b0001, 10, "post_reset_first_gnt");
    reset = 1'b1;
    #1 q.delete();
    req = 4'b0000;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("no_done_after_second_abort", n_done, 4);

    req_kind[5:4] = 2'd2;
    q.push_back('{gnt: 4'b0100, bg: 1'b1, erase: 1'b0, x: 9'd300, y: 8'd200, t: 5'd31, gap: 1'b0});
    @(posedge clock); #1;
    req = 4'b0100;
    req_cyc = cyc;
    wait_done(5, 77000, "bg_done");
    check("bg_req_to_done", done_cyc - req_cyc, 76804);
    req = 4'b0000;
    repeat (4) @(posedge clock);
    #1 check("idle_after_bg", allo[42:34], 0);

    check("multi_gnt", multi_gnt, 0);
    check("multi_done", multi_done, 0);
    check("busy_vs_gnt", busy_bad, 0);
    check("stray_erase_done", stray_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
